// File: rtl/embed_fetcher.sv
// rtl/embed_fetcher.sv - token-id to embedding-vector streaming fetcher
//
// Reads token ids from the encoder output RAM, looks up each id's embedding
// vector in the embedding RAM and streams the elements one by one over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cs               run enable; low aborts any run and returns to idle
//   enc_done         encoder finished, tok_count is valid
//   tok_count        number of token ids to stream (0..2^ADDR_WIDTH)
//   tok_addr/data    encoder output RAM read port (combinational read)
//   emb_addr/data    embedding RAM read port (combinational read)
//   out_valid/ready  output handshake
//   out_data         embedding element
//   out_last         last element of the current token's vector
//   out_tok          token index of the element on out_data
//   done             all tokens streamed
module embed_fetcher #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EMB_DIM    = 4,
  parameter int EMB_WIDTH  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cs,
  input  logic                                   enc_done,
  input  logic [ADDR_WIDTH:0]                    tok_count,
  output logic [ADDR_WIDTH-1:0]                  tok_addr,
  input  logic [DATA_WIDTH-1:0]                  tok_data,
  output logic [DATA_WIDTH+$clog2(EMB_DIM)-1:0]  emb_addr,
  input  logic [EMB_WIDTH-1:0]                   emb_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EMB_WIDTH-1:0]                   out_data,
  output logic                                   out_last,
  output logic [ADDR_WIDTH-1:0]                  out_tok,
  output logic                                   done
);

  localparam int JW = $clog2(EMB_DIM);
  localparam int EW = DATA_WIDTH + JW;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_ENC = 3'd1;
  localparam logic [2:0] S_READ_TOK = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_EMIT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_t;
  logic [JW-1:0]         r_j;
  logic [EW-1:0]         r_emb_addr;
  logic                  r_out_valid;
  logic [EMB_WIDTH-1:0]  r_out_data;
  logic                  r_out_last;
  logic [ADDR_WIDTH-1:0] r_out_tok;
  logic                  r_done;

  logic                  w_hs;
  logic                  w_last_elem;
  logic [ADDR_WIDTH:0]   w_t_next;
  logic                  w_more_tok;

  assign w_hs        = r_out_valid & out_ready;
  // EMB_DIM is a power of two, so the last element index is all ones.
  assign w_last_elem = &r_j;
  // One bit wider than t so that count = 2^ADDR_WIDTH compares without wrap.
  assign w_t_next    = {1'b0, r_t} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_more_tok  = (w_t_next < r_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_t         <= '0;
      r_j         <= '0;
      r_emb_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_tok   <= '0;
      r_done      <= 1'b0;
    end else if (!cs) begin
      // Abort has priority over everything, including a pending handshake.
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_j         <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT_ENC;
        end
        S_WAIT_ENC: begin
          if (enc_done) begin
            r_count <= tok_count;
            if (tok_count == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_t     <= '0;
              r_state <= S_READ_TOK;
            end
          end
        end
        S_READ_TOK: begin
          r_emb_addr <= {tok_data, {JW{1'b0}}};
          r_j        <= '0;
          r_state    <= S_FETCH;
        end
        S_FETCH: begin
          r_out_data  <= emb_data;
          r_out_valid <= 1'b1;
          r_out_last  <= w_last_elem;
          r_out_tok   <= r_t;
          r_state     <= S_EMIT;
        end
        S_EMIT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            if (!w_last_elem) begin
              r_j        <= r_j + 1'b1;
              r_emb_addr <= r_emb_addr + 1'b1;
              r_state    <= S_FETCH;
            end else if (w_more_tok) begin
              r_t     <= w_t_next[ADDR_WIDTH-1:0];
              r_state <= S_READ_TOK;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // tok_addr is the token index itself: it only ever advances while t < count-1.
  assign tok_addr  = r_t;
  assign emb_addr  = r_emb_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_tok   = r_out_tok;
  assign done      = r_done;

endmodule

// File: tb/tb_embed_fetcher.sv
// tb/tb_embed_fetcher.sv - self-checking bench for embed_fetcher
module tb_embed_fetcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic       enc_done = 1'b0;
  logic [4:0] tok_count = '0;
  logic [3:0] tok_addr;
  logic [7:0] tok_data;
  logic [9:0] emb_addr;
  logic [7:0] emb_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic [3:0] out_tok;
  logic       done;

  logic [7:0] tok_mem [16];
  logic [7:0] emb_mem [1024];

  assign tok_data = tok_mem[tok_addr];
  assign emb_data = emb_mem[emb_addr];

  embed_fetcher dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .enc_done(enc_done), .tok_count(tok_count),
    .tok_addr(tok_addr), .tok_data(tok_data), .emb_addr(emb_addr), .emb_data(emb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_tok(out_tok), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [3:0] tk;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] obs_d [$];
  logic       obs_l [$];
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int ready_mode = 0;
  int max_emb = 0;
  int max_tok = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Output-ready pattern generator, driven just after each rising edge.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (cyc % 6 == 5);
        default: out_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  // Compare process: checks every presented/accepted element against the model.
  initial begin
    bit         prev_stall = 1'b0;
    bit         done_due = 1'b0;
    logic [7:0] p_d = '0;
    logic       p_l = 1'b0;
    logic [3:0] p_t = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n && cs) begin
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, p_d);
          chk("hold_last", out_last, p_l);
          chk("hold_tok", out_tok, p_t);
        end
        if (done_due) begin
          chk("done_after_last", {done, out_valid}, 2'b10);
          done_due = 1'b0;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_element", out_valid, 0);
          end else if (out_ready) begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.l);
            chk("out_tok", out_tok, e.tk);
            obs_d.push_back(out_data);
            obs_l.push_back(out_last);
            hs_cnt++;
            if (exp_q.size() == 0) done_due = 1'b1;
          end
        end
        if (int'(emb_addr) > max_emb) max_emb = int'(emb_addr);
        if (int'(tok_addr) > max_tok) max_tok = int'(tok_addr);
        prev_stall = out_valid && !out_ready;
        p_d = out_data;
        p_l = out_last;
        p_t = out_tok;
      end else begin
        prev_stall = 1'b0;
        done_due = 1'b0;
      end
    end
  end

  // Reference model: element j of token t is emb[id(t)*EMB_DIM + j].
  task automatic prep(input int cnt);
    exp_q.delete();
    obs_d.delete();
    obs_l.delete();
    hs_cnt = 0;
    max_emb = 0;
    max_tok = 0;
    for (int t = 0; t < cnt; t++)
      for (int j = 0; j < 4; j++)
        exp_q.push_back('{emb_mem[int'(tok_mem[t]) * 4 + j], (j == 3), 4'(t)});
  endtask

  task automatic run(input int cnt, input int rmode);
    int k;
    prep(cnt);
    ready_mode = rmode;
    cs = 1'b1;
    tok_count = 5'(cnt);
    @(posedge clk); #1;
    enc_done = 1'b1;
    @(posedge clk); #1;
    enc_done = 1'($urandom_range(0, 1));
    tok_count = 5'($urandom);
    @(posedge clk); #1;
    chk("latency_e1", out_valid, 0);
    @(posedge clk); #1;
    if (cnt > 0) chk("latency_e2", out_valid, 1);
    else         chk("zero_count_done", done, 1);
    k = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_reached", done, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_holds", {done, out_valid}, 2'b10);
    chk("handshake_count", hs_cnt, cnt * 4);
    chk("model_drained", exp_q.size(), 0);
    cs = 1'b0;
    enc_done = 1'b0;
    @(posedge clk); #1;
    chk("done_cleared", done, 0);
  endtask

  initial begin
    logic [7:0] lit_d [8];
    int k;
    lit_d = '{8'd12, 8'd13, 8'd14, 8'd15, 8'd20, 8'd21, 8'd22, 8'd23};
    for (int i = 0; i < 1024; i++) emb_mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) tok_mem[i] = 8'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_last, done, out_data, out_tok, tok_addr, emb_addr}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Two tokens {3,5}, identity embedding table.
    tok_mem[0] = 8'd3;
    tok_mem[1] = 8'd5;
    run(2, 0);
    chk("lit_count", obs_d.size(), 8);
    for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
      chk("lit_data", obs_d[i], lit_d[i]);
      chk("lit_last", obs_l[i], (i % 4 == 3));
    end

    // Single token with long stalls on every element.
    tok_mem[0] = 8'd77;
    run(1, 2);
    chk("stall_count", obs_d.size(), 4);

    // Empty run.
    run(0, 0);

    // Full RAM, maximum ids.
    for (int i = 0; i < 16; i++) tok_mem[i] = 8'd255;
    for (int i = 1020; i < 1024; i++) emb_mem[i] = 8'($urandom);
    run(16, 0);
    chk("max_emb_addr", max_emb, 1023);
    chk("max_tok_addr", max_tok, 15);

    // Abort during the third element, then rerun from the start.
    tok_mem[0] = 8'd9;
    tok_mem[1] = 8'd40;
    prep(2);
    ready_mode = 0;
    cs = 1'b1;
    tok_count = 5'd2;
    @(posedge clk); #1;
    enc_done = 1'b1;
    k = 0;
    while (!(out_valid && hs_cnt == 2) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_reached_third", hs_cnt, 2);
    cs = 1'b0;
    enc_done = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", {out_valid, done}, 0);
    run(2, 0);

    // Asynchronous reset in the middle of EMIT.
    chk_en = 1'b0;
    tok_mem[0] = 8'd200;
    ready_mode = 3;
    cs = 1'b1;
    tok_count = 5'd1;
    @(posedge clk); #1;
    enc_done = 1'b1;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reset_pre_valid", out_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cs = 1'b0;
    #1;
    chk("async_reset_outputs", {out_valid, out_last, done, out_data, out_tok, tok_addr, emb_addr}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_reset", {out_valid, done, tok_addr, emb_addr}, 0);
    enc_done = 1'b0;
    chk_en = 1'b1;
    run(1, 1);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) tok_mem[i] = 8'($urandom);
      for (int i = 0; i < 1024; i++) emb_mem[i] = 8'($urandom);
      run(int'($urandom_range(1, 16)), (r % 3 == 2) ? 2 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/embed_fetcher.md
EMBED_FETCHER -- requirements
Module: embed_fetcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, width of the token-RAM address (the encoder output-RAM address).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of one token id.
REQ-003 SHALL have parameter EMB_DIM, default 4, elements per embedding vector; power of two, at least 2.
REQ-004 SHALL have parameter EMB_WIDTH, default 8, width of one embedding element.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cs  in  1  chip select; high = run, low = abort or idle.
REQ-008 enc_done  in  1  encoder finished; its output RAM holds tok_count valid ids.
REQ-009 tok_count  in  ADDR_WIDTH+1  number of tokens produced; legal range 0..2^ADDR_WIDTH.
REQ-010 tok_addr  out  ADDR_WIDTH  read address into the encoder output RAM.
REQ-011 tok_data  in  DATA_WIDTH  token id at tok_addr; combinational read, valid in the same cycle.
REQ-012 emb_addr  out  DATA_WIDTH+log2(EMB_DIM)  embedding-RAM address, equal to id*EMB_DIM + element index.
REQ-013 emb_data  in  EMB_WIDTH  embedding element at emb_addr; combinational read.
REQ-014 out_valid, out_ready  out/in  1  streaming handshake to the downstream consumer.
REQ-015 out_data  out  EMB_WIDTH  current embedding element.
REQ-016 out_last  out  1  marks the final element of each token's vector.
REQ-017 out_tok  out  ADDR_WIDTH  index of the token whose element is on out_data.
REQ-018 done  out  1  all tokens streamed.

Function
REQ-019 SHALL implement the states IDLE, WAIT_ENC, READ_TOK, FETCH, EMIT and DONE.
REQ-020 IDLE: cs=1 -> WAIT_ENC; otherwise stay in IDLE.
REQ-021 WAIT_ENC: on enc_done=1, capture tok_count.
- If the captured count is 0 -> DONE.
- Otherwise set token index t=0 and tok_addr=0 -> READ_TOK.
REQ-022 READ_TOK: latch id=tok_data, set element index j=0 and emb_addr=id*EMB_DIM -> FETCH.
REQ-023 FETCH: load out_data=emb_data, set out_valid=1, out_last=(j==EMB_DIM-1), out_tok=t -> EMIT.
REQ-024 EMIT: hold out_valid, out_data, out_last and out_tok stable until out_valid&out_ready is sampled at a rising edge.
REQ-025 On that handshake edge out_valid SHALL clear, then:
- j<EMB_DIM-1: increment j and emb_addr -> FETCH.
- Otherwise, t<count-1: increment t and tok_addr -> READ_TOK.
- Otherwise -> DONE.
REQ-026 Latency: out_valid SHALL first rise 2 rising edges after the edge that samples enc_done=1 in WAIT_ENC.
REQ-027 Throughput: consecutive elements SHALL take at most 2 cycles each with out_ready held high; a token change SHALL add 1 cycle.
REQ-028 DONE: done=1 and out_valid=0; stay in DONE while cs=1; cs=0 -> IDLE with done cleared.
REQ-029 cs=0 sampled in any non-IDLE state SHALL return to IDLE on that edge and clear out_valid, done, t and j; partial output is discarded.
REQ-030 The captured tok_count SHALL be used for the whole run; changes on tok_count or enc_done after capture SHALL be ignored.
REQ-031 emb_addr arithmetic SHALL be exact and unsigned, with no overflow for any DATA_WIDTH id.
REQ-032 tok_addr SHALL never exceed count-1; a count of 2^ADDR_WIDTH SHALL read address 2^ADDR_WIDTH-1 last, with no wrap.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE.
REQ-034 rst_n=0 SHALL immediately clear out_valid, out_last, done, out_data, out_tok, tok_addr, emb_addr, t and j to 0, regardless of clk.
REQ-035 After rst_n rises, the block SHALL wait for a cs=1 sample before leaving IDLE.

Verification
REQ-036 Two tokens, ids {3,5}, with emb[i]=i and out_ready=1 -> out_data sequence 12,13,14,15,20,21,22,23; out_last on 15 and 23; done 1 cycle after the last handshake.
REQ-037 One token, out_ready low for 5 cycles on each element -> out_data, out_last and out_tok hold stable while stalled; no element is lost or duplicated.
REQ-038 tok_count=0 with enc_done=1 -> DONE with no out_valid pulse; done=1 until cs drops.
REQ-039 tok_count=16, all ids 255 -> emb_addr reaches 1023, tok_addr reaches 15 with no wrap; 64 handshakes then done.
REQ-040 cs dropped during the 3rd element -> IDLE next edge, out_valid=0; a rerun with cs=1 restarts from t=0, j=0.
REQ-041 rst_n pulsed low mid-EMIT, between clock edges -> all outputs are 0 immediately; the block stays IDLE until cs=1.
